div_seq: RTL and testbench

Multi-cycle integer divide sequencer attached to the EX stage of the 5-stage MIPS pipeline. It accepts a divide request from EX and runs a radix-2 restoring divider for WIDTH cycles. While the divide is in flight it holds EX's stall request high, then presents {remainder, quotient} for the HI/LO write. EX owns the handshake; the pipeline controller sees only stallreq_o.

---
 rtl/div_seq_pkg.sv | 19 +
 rtl/div_seq_step.sv | 27 ++
 rtl/div_seq.sv | 141 ++++++++++++++
 tb/tb_div_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// div_seq shared defines: FSM encodings, handshake levels, default width.
// Imported by div_seq and div_step.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// div_step: one combinational radix-2 restoring step.
// Working register is {partial remainder, dividend/quotient bits, 1'b0}.
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0]  work_i,
  input  logic [WIDTH-1:0]  divisor_i,
  output logic [2*WIDTH:0]  work_o
);

  // Extra top bit: the shifted partial remainder can reach 2*divisor-1.
  logic [WIDTH+1:0] diff;
  logic             unused_top;

  assign diff = {1'b0, work_i[2*WIDTH:WIDTH]} - {2'b0, divisor_i};
  assign unused_top = diff[WIDTH];

  always_comb begin
    work_o = {work_i[2*WIDTH-1:0], 1'b0};
    if (!diff[WIDTH+1]) begin
      work_o = {diff[WIDTH-1:0], work_i[WIDTH-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divide sequencer for the EX stage.
// Define DIV_SIGNED_EN to honour signed_i (abs/sign-fixup logic).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH:0]   work_q;
  logic [2*WIDTH:0]   work_d;
  logic [WIDTH-1:0]   dvsr_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               accept;

  assign accept = (state_q == DIV_FREE) && (start_i == DivStart) && !annul_i;

  assign stallreq_o = accept
                    | (state_q == DIV_ON)
                    | (state_q == DIV_BYZERO);

  assign result_o = result_q;
  assign ready_o  = ready_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .work_i    (work_q),
    .divisor_i (dvsr_q),
    .work_o    (work_d)
  );

`ifdef DIV_SIGNED_EN
  logic sign_a_q;
  logic sign_b_q;
  logic signed_q;

  assign opa = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign opb = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  assign quo = (signed_q && (sign_a_q ^ sign_b_q)) ?
               -work_d[WIDTH-1:0] : work_d[WIDTH-1:0];
  assign rem = (signed_q && sign_a_q) ?
               -work_d[2*WIDTH:WIDTH+1] : work_d[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      signed_q <= 1'b0;
    end else if (accept) begin
      sign_a_q <= opdata1_i[WIDTH-1];
      sign_b_q <= opdata2_i[WIDTH-1];
      signed_q <= signed_i;
    end
  end
`else
  logic unused_signed;

  assign unused_signed = signed_i;
  assign opa = opdata1_i;
  assign opb = opdata2_i;
  assign quo = work_d[WIDTH-1:0];
  assign rem = work_d[2*WIDTH:WIDTH+1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_FREE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      ready_q  <= DivResultNotReady;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          if (accept) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q <= DIV_ON;
              work_q  <= {{WIDTH{1'b0}}, opa, 1'b0};
              dvsr_q  <= opb;
              cnt_q   <= '0;
            end
          end
        end
        DIV_BYZERO: begin
          if (annul_i) begin
            state_q <= DIV_FREE;
          end else begin
            work_q   <= '0;
            result_q <= '0;
            ready_q  <= DivResultReady;
            state_q  <= DIV_END;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state_q <= DIV_FREE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              result_q <= {rem, quo};
              ready_q  <= DivResultReady;
              state_q  <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (start_i == DivStop) begin
            state_q  <= DIV_FREE;
            result_q <= '0;
            ready_q  <= DivResultNotReady;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vectors for div_seq, hand-computed results.
// Signed expectations follow DIV_SIGNED_EN.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int n_chk;
  int n_bad;

  div_seq dut (
    .clk        (clk),
    .rst        (rst),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .start_i    (start_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drive a held start; count stall cycles and cycles until ready_o.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output int stalls, output int lat);
    @(negedge clk);
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i   = 1'b1;
    stalls    = 0;
    lat       = 0;
    #1;
    while (!ready_o && lat < 100) begin
      if (stallreq_o) stalls++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_start(input string tag);
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_clr"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_res_clr"}, result_o, 64'd0);
  endtask

  int stalls;
  int lat;

  initial begin
    n_chk     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i   = 1'b0;
    annul_i   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res", result_o, 64'd0);
    chk("rst_rdy", {63'd0, ready_o}, 64'd0);
    chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, stalls, lat);
    chk("u100_lat", 64'(lat), 64'd33);
    chk("u100_stalls", 64'(stalls), 64'd33);
    chk("u100_res", result_o, {32'd2, 32'd14});
    chk("u100_end_stall", {63'd0, stallreq_o}, 64'd0);
    release_start("u100");

    run_div(32'hFFFFFF9C, 32'd7, 1'b1, stalls, lat);
`ifdef DIV_SIGNED_EN
    chk("s_m100_res", result_o, {32'hFFFFFFFE, 32'hFFFFFFF2});
`else
    chk("s_m100_res", result_o, {32'd2, 32'h24924916});
`endif
    release_start("s_m100");

    run_div(32'hFFFFFFFF, 32'd2, 1'b0, stalls, lat);
    chk("umax_res", result_o, {32'd1, 32'h7FFFFFFF});
    release_start("umax");

    run_div(32'd55, 32'd0, 1'b0, stalls, lat);
    chk("dz_lat", 64'(lat), 64'd2);
    chk("dz_stalls", 64'(stalls), 64'd2);
    chk("dz_res", result_o, 64'd0);
    chk("dz_rdy", {63'd0, ready_o}, 64'd1);
    release_start("dz");

    // Annul at ON cycle 10.
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    signed_i  = 1'b0;
    start_i   = 1'b1;
    repeat (10) @(negedge clk);
    chk("an_on_stall", {63'd0, stallreq_o}, 64'd1);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    chk("an_stall", {63'd0, stallreq_o}, 64'd0);
    chk("an_rdy", {63'd0, ready_o}, 64'd0);
    repeat (30) @(negedge clk);
    chk("an_rdy_late", {63'd0, ready_o}, 64'd0);
    run_div(32'd1000, 32'd3, 1'b0, stalls, lat);
    chk("an_next_lat", 64'(lat), 64'd33);
    chk("an_next_res", result_o, {32'd1, 32'd333});
    release_start("an");

    // Reset mid-ON, then a held start through END.
    @(negedge clk);
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h10;
    start_i   = 1'b1;
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    chk("rmid_res", result_o, 64'd0);
    chk("rmid_rdy", {63'd0, ready_o}, 64'd0);
    chk("rmid_stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b0;
    run_div(32'h12345678, 32'h10, 1'b0, stalls, lat);
    chk("hold_lat", 64'(lat), 64'd33);
    chk("hold_res0", result_o, {32'd8, 32'h01234567});
    repeat (5) @(negedge clk);
    chk("hold_res", result_o, {32'd8, 32'h01234567});
    chk("hold_rdy", {63'd0, ready_o}, 64'd1);
    chk("hold_stall", {63'd0, stallreq_o}, 64'd0);
    release_start("hold");

    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, stalls, lat);
`ifdef DIV_SIGNED_EN
    chk("ovf_res", result_o, {32'd0, 32'h80000000});
`else
    chk("ovf_res", result_o, {32'h80000000, 32'd0});
`endif
    release_start("ovf");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
